instr_encoder: RTL and testbench

Packs instruction fields (opcode, src1, src2, dest) into the 8-bit instruction word consumed by the decoder. Field values that the 8-bit format cannot carry are checked and rejected. Each accepted instruction gets a sequential program address. Encoded words are buffered in a small first-word-fall-through FIFO for the instruction-memory loader. The block sits between the host/program-load path and instruction memory, and is the write-side counterpart of the decoder.

---
 rtl/instr_encoder.sv | 113 +++++++++++
 tb/tb_instr_encoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs opcode/src1/src2/dest fields into 8-bit instruction words.
// Illegal tuples are rejected; legal words queue in a FWFT FIFO with addresses.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [3:0]        in_src1,
  input  logic [3:0]        in_src2,
  input  logic [3:0]        in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              reject_pulse,
  output logic [7:0]        reject_count,
  output logic [CW-1:0]     count
);

  logic [7:0]        instr_q [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pulse_q, pulse_d;
  logic [7:0]        rej_q, rej_d;

  logic accept, legal, push, pop;
  logic [7:0] enc;

  assign in_ready = (count_q < CW'(DEPTH)) && !flush;
  assign accept   = in_valid && in_ready;
  assign legal    = (in_opcode <= 3'd4)
                 && (in_src1[3:2] == 2'b00)
                 && (in_src2[3:2] == 2'b00)
                 && (in_dest[3:1] == 3'b000);
  assign push     = accept && legal;
  assign pop      = out_valid && out_ready;
  assign enc      = {in_opcode, in_src1[1:0],
                     in_src2[1:0], in_dest[0]};

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    pulse_d   = accept && !legal;
    rej_d     = rej_q;
    if (accept && !legal && rej_q != 8'hFF)
      rej_d = rej_q + 8'd1;
    // flush wipes the queue but keeps the reject history
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      wr_addr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      pulse_q   <= 1'b0;
      rej_q     <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      pulse_q   <= pulse_d;
      rej_q     <= rej_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_q[wr_ptr_q] <= enc;
      addr_q[wr_ptr_q]  <= wr_addr_q;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_instr    = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_addr     = out_valid ? addr_q[rd_ptr_q] : '0;
  assign reject_pulse = pulse_q;
  assign reject_count = rej_q;
  assign count        = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder against a queue-based
// model of the field packing, reject counter and FIFO behaviour.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready;
  logic [2:0]        in_opcode;
  logic [3:0]        in_src1, in_src2, in_dest;
  logic              out_valid, out_ready;
  logic [7:0]        out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              reject_pulse;
  logic [7:0]        reject_count;
  logic [CW-1:0]     count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src1(in_src1),
    .in_src2(in_src2), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .reject_pulse(reject_pulse),
    .reject_count(reject_count), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { int instr; int addr; } exp_t;
  exp_t exp_q[$];
  int   m_addr, m_rej;
  bit   m_pulse;
  int   tests = 0, fails = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge from pre-edge inputs.
  always @(posedge clk) begin
    int  op, s1, s2, d;
    bit  acc, ok;
    op = in_opcode; s1 = in_src1; s2 = in_src2; d = in_dest;
    if (reset) begin
      exp_q.delete();
      m_addr = 0; m_rej = 0; m_pulse = 0;
    end else begin
      acc = in_valid && (exp_q.size() < DEPTH) && !flush;
      ok  = (op <= 4) && (s1 < 4) && (s2 < 4) && (d < 2);
      m_pulse = acc && !ok;
      if (acc && !ok && m_rej < 255) m_rej++;
      if (flush) begin
        exp_q.delete();
        m_addr = 0;
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (acc && ok) begin
          exp_q.push_back('{op*32 + s1*8 + s2*2 + d, m_addr});
          m_addr = (m_addr + 1) % (1 << ADDR_W);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      int ei, ea;
      ei = (exp_q.size() != 0) ? exp_q[0].instr : 0;
      ea = (exp_q.size() != 0) ? exp_q[0].addr  : 0;
      check("count", 32'(count), exp_q.size());
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("out_instr", 32'(out_instr), ei);
      check("out_addr", 32'(out_addr), ea);
      check("in_ready", 32'(in_ready),
            32'((exp_q.size() < DEPTH) && !flush));
      check("reject_pulse", 32'(reject_pulse), 32'(m_pulse));
      check("reject_count", 32'(reject_count), m_rej);
    end
  end

  task automatic step(input logic v, input logic [2:0] op,
                      input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] d, input logic ordy,
                      input logic fl);
    in_valid = v; in_opcode = op; in_src1 = s1;
    in_src2 = s2; in_dest = d; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic legal(input logic ordy, input logic fl);
    step(1'b1, 3'($urandom_range(0, 4)), 4'($urandom_range(0, 3)),
         4'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), ordy, fl);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_src1 = '0; in_src2 = '0; in_dest = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    step(1'b1, 3'd3, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0);
    #3 check("enc_0x73", 32'(out_instr), 32'h73);
    idle(2);

    step(1'b1, 3'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 3'd0, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 3'd0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0);
    legal(1'b1, 1'b0);
    idle(3);

    repeat (6) legal(1'b0, 1'b0);
    idle(6);

    repeat (257) legal(1'b1, 1'b0);
    idle(3);

    repeat (3) legal(1'b0, 1'b0);
    legal(1'b0, 1'b1);
    legal(1'b1, 1'b0);
    idle(3);

    repeat (3000) begin
      if ($urandom_range(0, 4) == 0)
        step(1'($urandom_range(0, 3) != 0), 3'($urandom),
             4'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 39) == 0));
      else
        legal(1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 39) == 0));
    end
    idle(5);

    repeat (260) step(1'b1, 3'd7, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    #3 check("reject_sat", 32'(reject_count), 32'd255);
    #2;
    reset = 1'b1;
    step(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    reset = 1'b0;
    #3 check("reject_after_reset", 32'(reject_count), 32'd0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
